// File: rtl/shift_pkg.sv
// Shared types and default sizing for the shift-register arbiter.
// Holds the arbiter state encoding and the default parameter values.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NREQ_D = 4;
    localparam int LENW_D = 3;
    localparam int WDT_D  = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Returns the winner both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    localparam int SW = IDXW + 1;

    logic [IDXW-1:0] cand [NREQ];
    logic [NREQ-1:0] hit;

    // cand[gi] is the requester visited gi steps after ptr, modulo NREQ
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum      = {1'b0, ptr} + SW'(gi);
            assign cand[gi] = (sum >= SW'(NREQ)) ? IDXW'(sum - SW'(NREQ)) : sum[IDXW-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
        onehot = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sequencing requesters onto an external shift datapath:
// grant, one-cycle counter load, wait for the counter to drain, then signal completion.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int LENW = LENW_D,
    parameter int WDT  = WDT_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    input  logic                 shift,
    input  logic                 wr,
    output logic                 load,
    output logic [LENW-1:0]      sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err
);

    localparam int IDXW = $clog2(NREQ);
    localparam int WCW  = $clog2(WDT + 1);

    state_t          state_reg, state_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [IDXW-1:0] widx_reg, widx_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic            load_reg, load_next;
    logic [LENW-1:0] sel_reg, sel_next;
    logic            err_reg, err_next;
    logic [WCW-1:0]  wdt_reg, wdt_next;

    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            widx_reg  <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            load_reg  <= 1'b0;
            sel_reg   <= '0;
            err_reg   <= 1'b0;
            wdt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            widx_reg  <= widx_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            load_reg  <= load_next;
            sel_reg   <= sel_next;
            err_reg   <= err_next;
            wdt_reg   <= wdt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        widx_next  = widx_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        load_next  = 1'b0;
        sel_next   = '0;
        err_next   = err_reg;
        wdt_next   = wdt_reg;

        if (wr && state_reg != RUN) begin
            err_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                wdt_next = '0;
                if (pick_valid) begin
                    state_next = LOAD;
                    gnt_next   = pick_onehot;
                    widx_next  = pick_idx;
                    ptr_next   = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            LOAD: begin
                load_next  = 1'b1;
                sel_next   = len[widx_reg*LENW +: LENW];
                state_next = RUN;
            end
            RUN: begin
                wdt_next = wdt_reg + 1'b1;
                // wdt_reg==0 marks the first RUN cycle, where shift cannot have risen yet
                if (wdt_reg != '0 && !shift) begin
                    state_next = DONE;
                    done_next  = gnt_reg;
                    gnt_next   = '0;
                end else if (wdt_reg == WCW'(WDT - 1)) begin
                    state_next = DONE;
                    gnt_next   = '0;
                    err_next   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign load = load_reg;
    assign sel  = sel_reg;
    assign gnt  = gnt_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-plus-random bench for shift_arbiter with a behavioural down-counter datapath
// and a transaction-level round-robin model.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int NREQ = NREQ_D;
    localparam int LENW = LENW_D;
    localparam int WDT  = WDT_D;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LENW-1:0] len = '0;
    logic                 shift;
    logic                 wr;
    logic                 load;
    logic [LENW-1:0]      sel;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cnt         = 0;
    logic force_shift = 1'b0;
    logic wr_inj      = 1'b0;
    int   ptr_m       = 0;
    logic err_m       = 1'b0;

    shift_arbiter #(.NREQ(NREQ), .LENW(LENW), .WDT(WDT)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .shift (shift),
        .wr    (wr),
        .load  (load),
        .sel   (sel),
        .gnt   (gnt),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // External datapath: loadable down-counter, busy while non-zero, strobe on last bit
    always @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= 0;
        else if (load)     cnt <= int'(sel);
        else if (cnt != 0) cnt <= cnt - 1;
    end
    assign shift = force_shift || (cnt != 0);
    assign wr    = (cnt == 1) || wr_inj;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int len_of(input int i);
        return int'(len[i*LENW +: LENW]);
    endfunction

    task automatic reset_dut;
        rst = 1'b0;
        req = '0;
        tick;
        tick;
        rst   = 1'b1;
        ptr_m = 0;
        err_m = 1'b0;
    endtask

    // One full transaction from IDLE; leaves the FSM in IDLE at return
    task automatic do_txn(input logic [NREQ-1:0] r, input bit drop, output int won);
        int w, lx, wr_seen, i;
        w     = model_pick(r, ptr_m);
        lx    = len_of(w);
        ptr_m = (w + 1) % NREQ;
        req   = r;
        tick;
        chk("gnt", 32'(gnt), 32'(1) << w);
        chk("load_early", 32'(load), 0);
        won = -1;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) won = k;
        if (drop) req = '0;
        tick;
        chk("load", 32'(load), 1);
        chk("sel", 32'(sel), lx);
        len     = (NREQ*LENW)'($urandom);
        wr_seen = 0;
        for (i = 1; i <= 40; i++) begin
            tick;
            if (wr) wr_seen++;
            if (done != '0) break;
        end
        $display("txn req=%b winner=%0d len=%0d run_cycles=%0d done=%b", r, w, lx, i, done);
        chk("run_len", i, lx + 2);
        chk("done", 32'(done), 32'(1) << w);
        chk("gnt_cleared", 32'(gnt), 0);
        chk("wr_count", wr_seen, (lx > 0) ? 1 : 0);
        tick;
        chk("done_pulse", 32'(done), 0);
        chk("err", 32'(err), 32'(err_m));
    endtask

    initial begin
        int won, i, done_hits;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] r;

        // Reset state
        tick;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset_dut;

        // Single requester, length 3
        len = '0;
        len[0*LENW +: LENW] = 3'd3;
        do_txn(4'b0001, 1'b0, won);

        // All requesting, all length 1: rotation from 0
        reset_dut;
        for (int k = 0; k < NREQ; k++) len[k*LENW +: LENW] = LENW'(1);
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < NREQ; k++) len[k*LENW +: LENW] = LENW'(1);
            do_txn(4'b1111, 1'b0, won);
            chk("rr_order", won, order[j]);
        end
        req = '0;
        tick;

        // Zero length
        len[2*LENW +: LENW] = '0;
        do_txn(4'b0100, 1'b0, won);

        // Request dropped right after grant
        do_txn(4'b0001, 1'b1, won);

        // Random traffic
        for (int j = 0; j < 30; j++) begin
            r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            len = (NREQ*LENW)'($urandom);
            do_txn(r, 1'($urandom_range(0, 1)), won);
            req = '0;
            repeat ($urandom_range(0, 2)) tick;
            chk("idle_gnt", 32'(gnt), 0);
        end

        // Reset in the middle of requester 3's RUN
        reset_dut;
        len = '0;
        len[3*LENW +: LENW] = 3'd5;
        req = 4'b1000;
        tick;
        chk("r3_gnt", 32'(gnt), 32'b1000);
        tick;
        tick;
        tick;
        #3;
        rst = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_load", 32'(load), 0);
        tick;
        chk("abort_done_held", 32'(done), 0);
        rst   = 1'b1;
        ptr_m = 0;
        err_m = 1'b0;
        len[0*LENW +: LENW] = 3'd2;
        do_txn(4'b1001, 1'b0, won);
        chk("post_reset_winner", won, 0);
        req = '0;
        tick;

        // Watchdog: shift stuck high
        force_shift = 1'b1;
        len[1*LENW +: LENW] = 3'd2;
        req = 4'b0010;
        tick;
        chk("wdt_gnt", 32'(gnt), 32'b0010);
        tick;
        chk("wdt_load", 32'(load), 1);
        done_hits = 0;
        for (i = 1; i <= 40; i++) begin
            tick;
            if (done != '0) done_hits++;
            if (err) break;
        end
        req         = '0;
        force_shift = 1'b0;
        $display("txn watchdog err after run_cycles=%0d", i);
        chk("wdt_cycle", i, WDT);
        chk("wdt_gnt_cleared", 32'(gnt), 0);
        tick;
        chk("wdt_no_done", 32'(done) | 32'(done_hits), 0);
        chk("wdt_err", 32'(err), 1);
        tick;
        chk("wdt_idle_gnt", 32'(gnt), 0);
        chk("wdt_err_sticky", 32'(err), 1);
        reset_dut;
        chk("err_cleared", 32'(err), 0);

        // Stray write strobe outside RUN
        wr_inj = 1'b1;
        tick;
        wr_inj = 1'b0;
        chk("stray_wr_err", 32'(err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
